// File: rtl/pattern_tx.sv
// Serializes a captured 8-bit pattern LSB first on w, with optional looping
// through a one-cycle gap and an abort input. One-hot FSM, async reset.
module pattern_tx (
  input  logic       clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [7:0] pattern,
  input  logic [3:0] len,
  input  logic       repeat_en,
  input  logic       stop,
  output logic       w,
  output logic       busy,
  output logic       done,
  output logic [3:0] state
);

  localparam int IDLE = 0;
  localparam int SEND = 1;
  localparam int GAP  = 2;
  localparam int DONE = 3;

  logic [3:0] state_reg;
  logic [3:0] state_next;
  logic [7:0] shadow_reg;
  logic [3:0] n_reg;
  logic [2:0] bit_idx_reg;
  logic       last_bit;
  logic       capture;

  assign last_bit = ({1'b0, bit_idx_reg} == (n_reg - 4'd1));
  assign capture  = state_reg[IDLE] && start && !stop && (len != 4'd0);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= 4'b0001;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = 4'b0000;
    unique case (1'b1)
      state_reg[IDLE]: begin
        if (start && !stop) begin
          if (len == 4'd0) state_next[DONE] = 1'b1;
          else             state_next[SEND] = 1'b1;
        end else begin
          state_next[IDLE] = 1'b1;
        end
      end
      state_reg[SEND]: begin
        if (stop)                       state_next[DONE] = 1'b1;
        else if (last_bit && repeat_en) state_next[GAP]  = 1'b1;
        else if (last_bit)              state_next[DONE] = 1'b1;
        else                            state_next[SEND] = 1'b1;
      end
      state_reg[GAP]: begin
        if (stop) state_next[DONE] = 1'b1;
        else      state_next[SEND] = 1'b1;
      end
      state_reg[DONE]: state_next[IDLE] = 1'b1;
      default:         state_next[IDLE] = 1'b1;
    endcase
  end

  // Shadow copies freeze the stream so input changes mid-flight have no effect.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      shadow_reg  <= 8'd0;
      n_reg       <= 4'd0;
      bit_idx_reg <= 3'd0;
    end else begin
      if (capture) begin
        shadow_reg <= pattern;
        n_reg      <= (len > 4'd8) ? 4'd8 : len;
      end
      if (state_reg[SEND] && !stop && !last_bit) begin
        bit_idx_reg <= bit_idx_reg + 3'd1;
      end else begin
        bit_idx_reg <= 3'd0;
      end
    end
  end

  always_comb begin
    w     = state_reg[SEND] & shadow_reg[bit_idx_reg];
    busy  = state_reg[SEND] | state_reg[GAP];
    done  = state_reg[DONE];
    state = state_reg;
  end

endmodule
